// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control unit: sequences fetch/decode/execute/mem/write-back and drives datapath selects.
// Latency: 2-5 cycles per instruction; outputs are decoded from the registered state (BRANCH pc_write follows alu_zero).
// Backpressure: none; the controller advances every cycle and never stalls.
module mc_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        alu_zero,
    output logic [2:0]  alu_ctrl,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  ext_op,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        ir_write,
    output logic        i_or_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic [1:0]  reg_dst,
    output logic [1:0]  mem_to_reg,
    output logic        illegal,
    output logic [3:0]  state_o,
    output logic [31:0] retired
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEM_ADR = 4'd3,
        S_MEM_RD  = 4'd4,
        S_MEM_WB  = 4'd5,
        S_MEM_WR  = 4'd6,
        S_EXE_R   = 4'd7,
        S_EXE_I   = 4'd8,
        S_ALU_WB  = 4'd9,
        S_BRANCH  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_NOP   = 6'b000000;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;

    state_t      state;
    state_t      next_state;
    logic [31:0] retired_cnt;

    logic is_rtype;
    logic is_r_alu;
    logic is_jr;
    logic is_nop;
    logic is_jump;
    logic is_mem;

    // Instruction class decode shared by the transition and output logic
    always_comb begin
        is_rtype = (opcode == OP_RTYPE);
        is_r_alu = is_rtype && ((funct == FN_ADDU) || (funct == FN_SUBU) ||
                                (funct == FN_AND)  || (funct == FN_OR)   ||
                                (funct == FN_XOR));
        is_jr    = is_rtype && (funct == FN_JR);
        is_nop   = is_rtype && (funct == FN_NOP);
        is_jump  = (opcode == OP_J) || (opcode == OP_JAL) || is_jr;
        is_mem   = (opcode == OP_LW) || (opcode == OP_SW);
    end

    // Next-state selection; unused encodings fall back to IDLE
    always_comb begin
        next_state = S_IDLE;
        case (state)
            S_IDLE:    next_state = S_FETCH;
            S_FETCH:   next_state = S_DECODE;
            S_DECODE: begin
                if (is_mem)                  next_state = S_MEM_ADR;
                else if (is_r_alu)           next_state = S_EXE_R;
                else if (opcode == OP_ORI)   next_state = S_EXE_I;
                else if (opcode == OP_LUI)   next_state = S_ALU_WB;
                else if (opcode == OP_BEQ)   next_state = S_BRANCH;
                else if (is_jump)            next_state = S_JUMP;
                else                         next_state = S_FETCH;
            end
            S_MEM_ADR: next_state = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:  next_state = S_MEM_WB;
            S_MEM_WB:  next_state = S_FETCH;
            S_MEM_WR:  next_state = S_FETCH;
            S_EXE_R:   next_state = S_ALU_WB;
            S_EXE_I:   next_state = S_ALU_WB;
            S_ALU_WB:  next_state = S_FETCH;
            S_BRANCH:  next_state = S_FETCH;
            S_JUMP:    next_state = S_FETCH;
            default:   next_state = S_IDLE;
        endcase
    end

    // State register and retired-instruction counter; the first FETCH after IDLE is not a retirement
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            retired_cnt <= 32'd0;
        end else begin
            state <= next_state;
            if ((next_state == S_FETCH) && (state != S_IDLE))
                retired_cnt <= retired_cnt + 32'd1;
        end
    end

    // Moore output decode from state plus the held instruction fields
    always_comb begin
        alu_ctrl   = ALU_ADD;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        ext_op     = 2'b00;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        ir_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 2'b00;
        mem_to_reg = 2'b00;
        illegal    = 1'b0;
        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                ir_write  = 1'b1;
                alu_src_b = 2'b01;
                pc_write  = 1'b1;
            end
            S_DECODE: begin
                // Speculatively compute the branch target into ALUOut
                alu_src_b = 2'b11;
                ext_op    = 2'b01;
                illegal   = !(is_mem || is_r_alu || is_jump || is_nop ||
                              (opcode == OP_ORI) || (opcode == OP_LUI) ||
                              (opcode == OP_BEQ));
            end
            S_MEM_ADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                ext_op    = 2'b01;
            end
            S_MEM_RD: begin
                i_or_d   = 1'b1;
                mem_read = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b01;
            end
            S_MEM_WR: begin
                i_or_d    = 1'b1;
                mem_write = 1'b1;
            end
            S_EXE_R: begin
                alu_src_a = 1'b1;
                case (funct)
                    FN_SUBU: alu_ctrl = ALU_SUB;
                    FN_AND:  alu_ctrl = ALU_AND;
                    FN_OR:   alu_ctrl = ALU_OR;
                    FN_XOR:  alu_ctrl = ALU_XOR;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            S_EXE_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctrl  = ALU_OR;
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
                if (opcode == OP_LUI) begin
                    mem_to_reg = 2'b11;
                    ext_op     = 2'b10;
                end else if (is_rtype) begin
                    reg_dst = 2'b01;
                end
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_ctrl  = ALU_SUB;
                pc_src    = 2'b01;
                pc_write  = alu_zero;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = is_jr ? 2'b11 : 2'b10;
                if (opcode == OP_JAL) begin
                    // PC already holds PC+4, which is the link value
                    reg_write  = 1'b1;
                    reg_dst    = 2'b10;
                    mem_to_reg = 2'b10;
                end
            end
            default: begin
            end
        endcase
    end

    assign state_o = state;
    assign retired = retired_cnt;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed scenarios plus a randomized instruction stream.
// Reference model works per instruction kind: a state path and a per-state output table.
// Inputs are driven after the falling edge; outputs are sampled 1 time unit later.
module tb_mc_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        alu_zero;
    logic [2:0]  alu_ctrl;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  ext_op;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        ir_write;
    logic        i_or_d;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic [1:0]  reg_dst;
    logic [1:0]  mem_to_reg;
    logic        illegal;
    logic [3:0]  state_o;
    logic [31:0] retired;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [31:0] exp_retired;

    mc_ctrl dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct), .alu_zero(alu_zero),
        .alu_ctrl(alu_ctrl), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_op(ext_op),
        .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .illegal(illegal), .state_o(state_o), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] alu;
        logic       a;
        logic [1:0] b;
        logic [1:0] ext;
        logic       pcw;
        logic [1:0] pcs;
        logic       irw;
        logic       iod;
        logic       mr;
        logic       mw;
        logic       rw;
        logic [1:0] rd;
        logic [1:0] m2r;
        logic       ill;
        logic [3:0] st;
    } outs_t;

    localparam int K_LW = 0, K_SW = 1, K_ADDU = 2, K_SUBU = 3, K_AND = 4, K_OR = 5,
                   K_XOR = 6, K_ORI = 7, K_LUI = 8, K_BEQ = 9, K_J = 10, K_JAL = 11,
                   K_JR = 12, K_NOP = 13, K_ILL = 14;

    function automatic outs_t observed();
        outs_t o;
        o = {alu_ctrl, alu_src_a, alu_src_b, ext_op, pc_write, pc_src, ir_write, i_or_d,
             mem_read, mem_write, reg_write, reg_dst, mem_to_reg, illegal, state_o};
        return o;
    endfunction

    function automatic int path_len(int k);
        case (k)
            K_LW: return 5;
            K_SW, K_ADDU, K_SUBU, K_AND, K_OR, K_XOR, K_ORI: return 4;
            K_LUI, K_BEQ, K_J, K_JAL, K_JR: return 3;
            default: return 2;
        endcase
    endfunction

    // State visited at step i (0 = FETCH) of an instruction of kind k
    function automatic int path_state(int k, int i);
        if (i == 0) return 1;
        if (i == 1) return 2;
        case (k)
            K_LW:  return (i == 2) ? 3 : ((i == 3) ? 4 : 5);
            K_SW:  return (i == 2) ? 3 : 6;
            K_ADDU, K_SUBU, K_AND, K_OR, K_XOR: return (i == 2) ? 7 : 9;
            K_ORI: return (i == 2) ? 8 : 9;
            K_LUI: return 9;
            K_BEQ: return 10;
            default: return 11;
        endcase
    endfunction

    function automatic outs_t exp_out(int st, int k, logic zero);
        outs_t o;
        o = '0;
        o.alu = 3'b010;
        o.st  = st[3:0];
        case (st)
            1: begin o.mr = 1; o.irw = 1; o.b = 2'b01; o.pcw = 1; end
            2: begin o.b = 2'b11; o.ext = 2'b01; o.ill = (k == K_ILL); end
            3: begin o.a = 1; o.b = 2'b10; o.ext = 2'b01; end
            4: begin o.iod = 1; o.mr = 1; end
            5: begin o.rw = 1; o.m2r = 2'b01; end
            6: begin o.iod = 1; o.mw = 1; end
            7: begin
                o.a = 1;
                case (k)
                    K_SUBU: o.alu = 3'b011;
                    K_AND:  o.alu = 3'b000;
                    K_OR:   o.alu = 3'b001;
                    K_XOR:  o.alu = 3'b100;
                    default: o.alu = 3'b010;
                endcase
            end
            8: begin o.a = 1; o.b = 2'b10; o.alu = 3'b001; end
            9: begin
                o.rw = 1;
                if (k == K_LUI) begin o.m2r = 2'b11; o.ext = 2'b10; end
                else if (k != K_ORI) o.rd = 2'b01;
            end
            10: begin o.a = 1; o.alu = 3'b011; o.pcs = 2'b01; o.pcw = zero; end
            11: begin
                o.pcw = 1;
                o.pcs = (k == K_JR) ? 2'b11 : 2'b10;
                if (k == K_JAL) begin o.rw = 1; o.rd = 2'b10; o.m2r = 2'b10; end
            end
            default: ;
        endcase
        return o;
    endfunction

    function automatic logic legal_op(logic [5:0] op);
        return (op == 6'd0) || (op == 6'd2) || (op == 6'd3) || (op == 6'd4) ||
               (op == 6'd13) || (op == 6'd15) || (op == 6'd35) || (op == 6'd43);
    endfunction

    function automatic logic legal_rfn(logic [5:0] fn);
        return (fn == 6'd0) || (fn == 6'd8) || (fn == 6'd33) || (fn == 6'd35) ||
               (fn == 6'd36) || (fn == 6'd37) || (fn == 6'd38);
    endfunction

    task automatic set_instr(int k);
        logic [5:0] op, fn;
        op = 6'd0;
        fn = 6'($urandom_range(63));
        case (k)
            K_LW:   op = 6'b100011;
            K_SW:   op = 6'b101011;
            K_ADDU: fn = 6'b100001;
            K_SUBU: fn = 6'b100011;
            K_AND:  fn = 6'b100100;
            K_OR:   fn = 6'b100101;
            K_XOR:  fn = 6'b100110;
            K_ORI:  op = 6'b001101;
            K_LUI:  op = 6'b001111;
            K_BEQ:  op = 6'b000100;
            K_J:    op = 6'b000010;
            K_JAL:  op = 6'b000011;
            K_JR:   fn = 6'b001000;
            K_NOP:  fn = 6'b000000;
            default: begin
                if ($urandom_range(1) == 0) begin
                    op = 6'($urandom_range(63));
                    while (legal_op(op)) op = 6'($urandom_range(63));
                end else begin
                    while (legal_rfn(fn)) fn = 6'($urandom_range(63));
                end
            end
        endcase
        opcode = op;
        funct  = fn;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        outs_t o;
        reset_n = 1'b0; opcode = 6'd0; funct = 6'd0; alu_zero = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        o = observed();
        n_cmp++;
        if (o !== exp_out(0, K_NOP, 1'b0)) begin
            n_fail++; $display("FAIL reset_outputs: got %h want %h", o, exp_out(0, K_NOP, 1'b0));
        end
        n_cmp++;
        if (retired !== 32'd0) begin n_fail++; $display("FAIL reset_retired: got %0d want 0", retired); end
        exp_retired = 32'd0;
    endtask

    task automatic test_lw();
        int exp_st[6] = '{1, 2, 3, 4, 5, 1};
        @(negedge clk);
        reset_n = 1'b1;
        set_instr(K_LW);
        for (int i = 0; i < 6; i++) begin
            tick();
            n_cmp++;
            if (state_o !== 4'(exp_st[i]) ||
                mem_read !== ((exp_st[i] == 1) || (exp_st[i] == 4)) ||
                reg_write !== (exp_st[i] == 5)) begin
                n_fail++;
                $display("FAIL lw_step%0d: state %0d mr %b rw %b want state %0d", i, state_o,
                         mem_read, reg_write, exp_st[i]);
            end
        end
        exp_retired++;
        n_cmp++;
        if (retired !== exp_retired) begin n_fail++; $display("FAIL lw_retired: got %0d want %0d", retired, exp_retired); end
    endtask

    task automatic test_rtype();
        int kinds[2] = '{K_SUBU, K_XOR};
        logic [2:0] alus[2] = '{3'b011, 3'b100};
        for (int n = 0; n < 2; n++) begin
            set_instr(kinds[n]);
            tick();
            tick();
            n_cmp++;
            if (state_o !== 4'd7 || alu_ctrl !== alus[n]) begin
                n_fail++; $display("FAIL rtype%0d_exe: state %0d alu %b want 7 %b", n, state_o, alu_ctrl, alus[n]);
            end
            tick();
            n_cmp++;
            if (state_o !== 4'd9 || reg_dst !== 2'b01 || reg_write !== 1'b1) begin
                n_fail++; $display("FAIL rtype%0d_wb: state %0d reg_dst %b rw %b want 9 01 1", n, state_o, reg_dst, reg_write);
            end
            tick();
            exp_retired++;
            n_cmp++;
            if (state_o !== 4'd1 || retired !== exp_retired) begin
                n_fail++; $display("FAIL rtype%0d_cycles: state %0d retired %0d want 1 %0d", n, state_o, retired, exp_retired);
            end
        end
    endtask

    task automatic test_beq();
        for (int n = 0; n < 2; n++) begin
            set_instr(K_BEQ);
            tick();
            tick();
            alu_zero = 1'b1; #1;
            n_cmp++;
            if (state_o !== 4'd10 || pc_write !== 1'b1 || pc_src !== 2'b01) begin
                n_fail++; $display("FAIL beq_taken: state %0d pcw %b pcs %b want 10 1 01", state_o, pc_write, pc_src);
            end
            alu_zero = 1'b0; #1;
            n_cmp++;
            if (pc_write !== 1'b0) begin n_fail++; $display("FAIL beq_not_taken: pcw %b want 0", pc_write); end
            alu_zero = (n == 0);
            tick();
            alu_zero = 1'b0;
            exp_retired++;
            n_cmp++;
            if (state_o !== 4'd1) begin n_fail++; $display("FAIL beq_next: state %0d want 1", state_o); end
        end
    endtask

    task automatic test_jumps();
        set_instr(K_JAL);
        tick();
        tick();
        n_cmp++;
        if (state_o !== 4'd11 || pc_src !== 2'b10 || reg_dst !== 2'b10 || mem_to_reg !== 2'b10 ||
            reg_write !== 1'b1 || pc_write !== 1'b1) begin
            n_fail++; $display("FAIL jal: state %0d pcs %b rd %b m2r %b rw %b pcw %b", state_o, pc_src,
                               reg_dst, mem_to_reg, reg_write, pc_write);
        end
        tick();
        exp_retired++;
        set_instr(K_JR);
        tick();
        tick();
        n_cmp++;
        if (state_o !== 4'd11 || pc_src !== 2'b11 || reg_write !== 1'b0 || pc_write !== 1'b1) begin
            n_fail++; $display("FAIL jr: state %0d pcs %b rw %b pcw %b want 11 11 0 1", state_o, pc_src, reg_write, pc_write);
        end
        tick();
        exp_retired++;
    endtask

    task automatic test_illegal();
        opcode = 6'b111111; funct = 6'd0;
        n_cmp++;
        if (illegal !== 1'b0 || mem_write !== 1'b0 || reg_write !== 1'b0) begin
            n_fail++; $display("FAIL illegal_fetch: ill %b mw %b rw %b want 0 0 0", illegal, mem_write, reg_write);
        end
        tick();
        n_cmp++;
        if (state_o !== 4'd2 || illegal !== 1'b1 || mem_write !== 1'b0 || reg_write !== 1'b0 ||
            pc_write !== 1'b0 || ir_write !== 1'b0) begin
            n_fail++; $display("FAIL illegal_decode: state %0d ill %b mw %b rw %b pcw %b irw %b", state_o,
                               illegal, mem_write, reg_write, pc_write, ir_write);
        end
        tick();
        exp_retired++;
        n_cmp++;
        if (state_o !== 4'd1 || illegal !== 1'b0 || retired !== exp_retired) begin
            n_fail++; $display("FAIL illegal_after: state %0d ill %b retired %0d want 1 0 %0d", state_o, illegal, retired, exp_retired);
        end
    endtask

    task automatic test_random();
        outs_t o, e;
        int k, len;
        logic z;
        for (int n = 0; n < 60; n++) begin
            k = $urandom_range(K_ILL);
            set_instr(k);
            len = path_len(k);
            for (int i = 0; i < len; i++) begin
                if (i > 0) begin
                    @(negedge clk);
                    z = 1'($urandom_range(1));
                    alu_zero = z;
                    #1;
                end else begin
                    z = alu_zero;
                end
                o = observed();
                e = exp_out(path_state(k, i), k, z);
                n_cmp++;
                if (o !== e) begin
                    n_fail++; $display("FAIL rand%0d_kind%0d_step%0d: got %h want %h", n, k, i, o, e);
                end
            end
            tick();
            exp_retired++;
            n_cmp++;
            if (state_o !== 4'd1 || retired !== exp_retired) begin
                n_fail++; $display("FAIL rand%0d_retire: state %0d retired %0d want 1 %0d", n, state_o, retired, exp_retired);
            end
        end
        alu_zero = 1'b0;
    endtask

    task automatic test_reset_mid();
        set_instr(K_LW);
        tick();
        tick();
        tick();
        n_cmp++;
        if (state_o !== 4'd4) begin n_fail++; $display("FAIL mid_pre: state %0d want 4", state_o); end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (state_o !== 4'd0 || retired !== 32'd0 || mem_read !== 1'b0 || mem_write !== 1'b0 ||
            reg_write !== 1'b0 || pc_write !== 1'b0 || ir_write !== 1'b0 || alu_ctrl !== 3'b010) begin
            n_fail++; $display("FAIL mid_reset: state %0d retired %0d mr %b mw %b rw %b pcw %b irw %b alu %b",
                               state_o, retired, mem_read, mem_write, reg_write, pc_write, ir_write, alu_ctrl);
        end
        exp_retired = 32'd0;
        @(negedge clk);
        reset_n = 1'b1;
        opcode = 6'd0; funct = 6'd0;
        #1;
        n_cmp++;
        if (state_o !== 4'd0) begin n_fail++; $display("FAIL mid_hold: state %0d want 0", state_o); end
        tick();
        n_cmp++;
        if (state_o !== 4'd1 || retired !== 32'd0) begin
            n_fail++; $display("FAIL mid_restart: state %0d retired %0d want 1 0", state_o, retired);
        end
    endtask

    task automatic test_wrap();
        dut.retired_cnt = 32'hFFFF_FFFF;
        set_instr(K_NOP);
        tick();
        n_cmp++;
        if (state_o !== 4'd2 || illegal !== 1'b0) begin
            n_fail++; $display("FAIL wrap_decode: state %0d ill %b want 2 0", state_o, illegal);
        end
        tick();
        n_cmp++;
        if (state_o !== 4'd1 || retired !== 32'd0) begin
            n_fail++; $display("FAIL wrap_retired: state %0d retired %h want 1 00000000", state_o, retired);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_rtype();
        test_beq();
        test_jumps();
        test_illegal();
        test_random();
        test_reset_mid();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
